// File: rtl/pr_free_list.sv
`default_nettype none
// ============================================================================
// Module      : pr_free_list
// Description : Physical-register free list. It offers up to two tags per
//               cycle, reclaims tags released at commit, and keeps read-pointer
//               checkpoints for branch recall.
// Revision    : 1.0 - initial release
// ============================================================================
module pr_free_list #(
  parameter int NUM_PR   = 64,
  parameter int NUM_AR   = 32,
  parameter int NUM_FREE = 2,
  parameter int NUM_CKPT = 4,
  localparam int TAG_W   = $clog2(NUM_PR),
  localparam int DEPTH   = NUM_PR - NUM_AR,
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int PTR_W   = IDX_W + 1,
  localparam int CKPT_W  = $clog2(NUM_CKPT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        alloc_req,
  input  logic              ext_stall,
  output logic [TAG_W-1:0]  alloc_addr [2],
  output logic              alloc_ok,
  input  logic [NUM_FREE-1:0] free_valid,
  input  logic [TAG_W-1:0]  free_addr [NUM_FREE],
  input  logic              ckpt_save,
  input  logic [CKPT_W-1:0] ckpt_save_id,
  input  logic              if_recall,
  input  logic [CKPT_W-1:0] recall_id,
  output logic [PTR_W-1:0]  free_count,
  output logic              overflow_err
);

  localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(DEPTH);

  logic [TAG_W-1:0] r_buf [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W-1:0] r_ckpt_head [NUM_CKPT];
  logic             r_overflow;

  logic [1:0]       w_req_cnt;
  logic [PTR_W-1:0] w_head_p1;
  logic [TAG_W-1:0] w_tag0;
  logic [TAG_W-1:0] w_tag1;
  logic             w_fire;
  logic [PTR_W-1:0] w_head_alloc;

  logic [PTR_W:0]   w_room;
  logic [PTR_W:0]   w_accepted;
  logic [PTR_W-1:0] w_tail_next;
  logic             w_drop;
  logic [NUM_FREE-1:0] w_wr_en;
  logic [IDX_W-1:0] w_wr_idx [NUM_FREE];

  // Wrap-bit pointers make tail - head the exact occupancy, full included.
  assign free_count   = r_tail - r_head;
  assign overflow_err = r_overflow;

  assign w_req_cnt = {1'b0, alloc_req[0]} + {1'b0, alloc_req[1]};
  assign w_head_p1 = r_head + PTR_W'(1);
  assign w_tag0    = r_buf[r_head[IDX_W-1:0]];
  assign w_tag1    = r_buf[w_head_p1[IDX_W-1:0]];

  assign alloc_addr[0] = w_tag0;
  assign alloc_addr[1] = alloc_req[0] ? w_tag1 : w_tag0;
  assign alloc_ok      = (PTR_W'(w_req_cnt) <= free_count);

  assign w_fire       = alloc_ok & ~ext_stall & ~if_recall & (|alloc_req);
  assign w_head_alloc = r_head + (w_fire ? PTR_W'(w_req_cnt) : '0);

  // Room is measured against the count before this cycle's allocation.
  assign w_room = c_depth - {1'b0, free_count};

  always_comb begin
    w_tail_next = r_tail;
    w_accepted  = '0;
    w_drop      = 1'b0;
    for (int i = 0; i < NUM_FREE; i++) begin
      w_wr_en[i]  = 1'b0;
      w_wr_idx[i] = w_tail_next[IDX_W-1:0];
      if (free_valid[i]) begin
        if (w_accepted < w_room) begin
          w_wr_en[i]  = 1'b1;
          w_tail_next = w_tail_next + PTR_W'(1);
          w_accepted  = w_accepted + (PTR_W+1)'(1);
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= PTR_W'(DEPTH);
      r_overflow <= 1'b0;
      for (int c = 0; c < NUM_CKPT; c++) begin
        r_ckpt_head[c] <= '0;
      end
    end else begin
      r_tail <= w_tail_next;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (if_recall) begin
        r_head <= r_ckpt_head[recall_id];
      end else begin
        r_head <= w_head_alloc;
        if (ckpt_save) begin
          r_ckpt_head[ckpt_save_id] <= w_head_alloc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_buf[k] <= TAG_W'(NUM_AR + k);
      end
    end else begin
      for (int i = 0; i < NUM_FREE; i++) begin
        if (w_wr_en[i]) begin
          r_buf[w_wr_idx[i]] <= free_addr[i];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pr_free_list.sv
`default_nettype none
// ============================================================================
// Module      : tb_pr_free_list
// Description : Directed self-checking bench for pr_free_list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pr_free_list;

  logic       clk;
  logic       reset;
  logic [1:0] alloc_req;
  logic       ext_stall;
  logic [5:0] alloc_addr [2];
  logic       alloc_ok;
  logic [1:0] free_valid;
  logic [5:0] free_addr [2];
  logic       ckpt_save;
  logic [1:0] ckpt_save_id;
  logic       if_recall;
  logic [1:0] recall_id;
  logic [5:0] free_count;
  logic       overflow_err;

  int checks   = 0;
  int failures = 0;

  pr_free_list dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .ext_stall    (ext_stall),
    .alloc_addr   (alloc_addr),
    .alloc_ok     (alloc_ok),
    .free_valid   (free_valid),
    .free_addr    (free_addr),
    .ckpt_save    (ckpt_save),
    .ckpt_save_id (ckpt_save_id),
    .if_recall    (if_recall),
    .recall_id    (recall_id),
    .free_count   (free_count),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_req    = '0;
    ext_stall    = 1'b0;
    free_valid   = '0;
    free_addr[0] = '0;
    free_addr[1] = '0;
    ckpt_save    = 1'b0;
    ckpt_save_id = '0;
    if_recall    = 1'b0;
    recall_id    = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    do_reset();
    chk("reset_count", 32'(free_count), 32);
    chk("reset_ovf", 32'(overflow_err), 0);
    chk("reset_ok", 32'(alloc_ok), 1);
    chk("reset_offer0", 32'(alloc_addr[0]), 32);

    // Dual allocation from a fresh list
    alloc_req = 2'b11; #1;
    chk("dual_a0", 32'(alloc_addr[0]), 32);
    chk("dual_a1", 32'(alloc_addr[1]), 33);
    chk("dual_ok", 32'(alloc_ok), 1);
    tick();
    alloc_req = 2'b00; #1;
    chk("dual_count", 32'(free_count), 30);
    alloc_req = 2'b11; #1;
    chk("dual_next_a0", 32'(alloc_addr[0]), 34);
    chk("dual_next_a1", 32'(alloc_addr[1]), 35);

    // Slot 1 alone is compacted onto the head tag
    do_reset();
    alloc_req = 2'b10; #1;
    chk("slot1_a1", 32'(alloc_addr[1]), 32);
    tick();
    alloc_req = 2'b00; #1;
    chk("slot1_count", 32'(free_count), 31);
    chk("slot1_next_a0", 32'(alloc_addr[0]), 33);

    // 30 more singles leave one free entry
    alloc_req = 2'b01;
    repeat (30) tick();
    alloc_req = 2'b00; #1;
    chk("one_left_count", 32'(free_count), 1);
    alloc_req = 2'b11; #1;
    chk("one_left_dual_ok", 32'(alloc_ok), 0);
    tick();
    chk("one_left_no_alloc", 32'(free_count), 1);
    alloc_req = 2'b01; ext_stall = 1'b1; #1;
    chk("stall_ok", 32'(alloc_ok), 1);
    chk("stall_a0", 32'(alloc_addr[0]), 63);
    tick();
    chk("stall_count", 32'(free_count), 1);
    ext_stall = 1'b0;
    tick();
    alloc_req = 2'b00; #1;
    chk("empty_count", 32'(free_count), 0);
    alloc_req = 2'b01; #1;
    chk("empty_ok", 32'(alloc_ok), 0);
    alloc_req = 2'b00;

    // Release into the wrapped tail
    free_valid = 2'b11; free_addr[0] = 6'd5; free_addr[1] = 6'd7;
    tick();
    free_valid = 2'b00; alloc_req = 2'b11; #1;
    chk("release_count", 32'(free_count), 2);
    chk("release_a0", 32'(alloc_addr[0]), 5);
    chk("release_a1", 32'(alloc_addr[1]), 7);
    chk("release_ok", 32'(alloc_ok), 1);
    alloc_req = 2'b00;

    // Save at full, allocate 6, recall with one release; recall cycle must not allocate
    do_reset();
    ckpt_save = 1'b1; ckpt_save_id = 2'd2;
    tick();
    ckpt_save = 1'b0; alloc_req = 2'b11;
    repeat (3) tick();
    alloc_req = 2'b00; #1;
    chk("ckpt_pre_count", 32'(free_count), 26);
    if_recall = 1'b1; recall_id = 2'd2; alloc_req = 2'b11;
    free_valid = 2'b01; free_addr[0] = 6'd40;
    tick();
    clear_inputs(); #1;
    chk("recall_count", 32'(free_count), 33);

    // Recall to a mid-list checkpoint: offer returns to first tag after the save
    do_reset();
    alloc_req = 2'b11;
    tick();
    alloc_req = 2'b00; ckpt_save = 1'b1; ckpt_save_id = 2'd1;
    tick();
    ckpt_save = 1'b0; alloc_req = 2'b11;
    repeat (2) tick();
    alloc_req = 2'b00; if_recall = 1'b1; recall_id = 2'd1;
    free_valid = 2'b01; free_addr[0] = 6'd40;
    tick();
    clear_inputs(); #1;
    chk("recall1_count", 32'(free_count), 31);
    chk("recall1_a0", 32'(alloc_addr[0]), 34);

    // Save in an allocating cycle captures the post-allocation head
    do_reset();
    alloc_req = 2'b11;
    tick();
    ckpt_save = 1'b1; ckpt_save_id = 2'd3;
    tick();
    ckpt_save = 1'b0;
    tick();
    alloc_req = 2'b00; if_recall = 1'b1; recall_id = 2'd3;
    tick();
    clear_inputs(); #1;
    chk("recall3_count", 32'(free_count), 28);
    chk("recall3_a0", 32'(alloc_addr[0]), 36);

    // Release into a full list
    do_reset();
    free_valid = 2'b01; free_addr[0] = 6'd9;
    tick();
    free_valid = 2'b00; #1;
    chk("ovf_set", 32'(overflow_err), 1);
    chk("ovf_count", 32'(free_count), 32);
    repeat (3) tick();
    chk("ovf_sticky", 32'(overflow_err), 1);

    // Two releases with room for one: excess dropped
    do_reset();
    chk("ovf_cleared", 32'(overflow_err), 0);
    alloc_req = 2'b01;
    tick();
    alloc_req = 2'b00;
    free_valid = 2'b11; free_addr[0] = 6'd9; free_addr[1] = 6'd10;
    tick();
    free_valid = 2'b00; #1;
    chk("drop_count", 32'(free_count), 32);
    chk("drop_ovf", 32'(overflow_err), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
